dcache_ctrl: RTL
================

Name: dcache_ctrl

Overview:
- Responder side of the CPU data-memory interface (memRead/memWrite/address/write data -> read data).
- Replaces the single-cycle data memory with a direct-mapped, write-back, write-allocate cache.
- Backed by a slow block-wide memory over a req/ack handshake.
- Asserts stall_o to freeze the pipeline while a miss is serviced.

Parameters:
- LINES, 32, number of cache lines (power of 2).
- BLOCK_WORDS, 8, 32-bit words per line (power of 2); block width = 32*BLOCK_WORDS.

Ports:
- clk_i  in  1  clock, all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- memRead_i  in  1  CPU load request (MEM stage).
- memWrite_i  in  1  CPU store request (MEM stage).
- addr_i  in  32  CPU byte address; bits [1:0] ignored.
- wdata_i  in  32  CPU store data.
- rdata_o  out  32  load data.
- stall_o  out  1  pipeline freeze.
- mem_req_o  out  1  backing-memory request.
- mem_write_o  out  1  1 = block write, 0 = block read.
- mem_addr_o  out  32  block-aligned backing address.
- mem_wdata_o  out  32*BLOCK_WORDS  victim block data.
- mem_rdata_i  in  32*BLOCK_WORDS  refill block data.
- mem_ack_i  in  1  one-cycle completion pulse from backing memory.

Behaviour:
- Address split:
  - offset = addr[log2(BLOCK_WORDS)+1:2]
  - index = next log2(LINES) bits
  - tag = remaining upper bits (22 at defaults)
- Per line: valid, dirty, tag, data block.
- Reset (rst_i high at clock edge):
  - All valid and dirty bits cleared; FSM to IDLE.
  - stall_o=0, mem_req_o=0, mem_write_o=0, mem_addr_o=0, mem_wdata_o=0.
  - Reset mid-miss abandons the transfer; mem_req_o low the following cycle; any later ack ignored.
- Request = memRead_i | memWrite_i. If both are high, treat as a write.
- Hit = valid[index] & (tag match).
- IDLE, request, hit:
  - stall_o=0 (combinational, same cycle).
  - Read: rdata_o = selected word, same cycle (zero latency).
  - Write: the word is updated and dirty set at the clock edge.
  - Back-to-back hits sustain one access per cycle.
- IDLE, request, miss:
  - stall_o=1 combinationally in the same cycle.
  - Latch address, wdata and the read/write kind.
  - Go to WRITEBACK if the victim is valid and dirty, otherwise ALLOCATE.
- WRITEBACK:
  - mem_req_o=1, mem_write_o=1, mem_addr_o={victim tag, index, zeros}, mem_wdata_o=victim block.
  - Hold until mem_ack_i, then go to ALLOCATE.
- ALLOCATE:
  - mem_req_o=1, mem_write_o=0, mem_addr_o={latched tag, index, zeros}.
  - On mem_ack_i: load mem_rdata_i into the line; valid=1, dirty=0, tag updated; go to IDLE.
- Back in IDLE, the held request now hits; stall_o drops that cycle and the access completes as a normal hit (a write then sets dirty).
- stall_o=1 in every cycle of WRITEBACK and ALLOCATE.
- mem_req_o and its address/data stay stable from assertion until the cycle after ack.
- mem_ack_i is ignored in IDLE.
- rdata_o=0 when memRead_i=0 or when not hitting.
- The CPU holds its request while stall_o=1; the cache services the latched address regardless.

Optional Feature:
- Macro DCACHE_STATS_EN.
- Defined: adds outputs hit_cnt_o[31:0], miss_cnt_o[31:0] and wb_cnt_o[31:0].
  - hit_cnt_o increments once per completed access that hit on first lookup.
  - miss_cnt_o increments on each miss detection.
  - wb_cnt_o increments on each WRITEBACK ack.
  - All counters wrap at 2^32, clear on rst_i, and do not double-count the post-refill re-lookup.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Cold read: after reset, read 0x00000040; backing block word0=0xDEADBEEF; ack 10 cycles after req -> stall_o high 11 cycles, one read req at mem_addr 0x40, then rdata_o=0xDEADBEEF with stall_o=0.
- Write hit: write 0x12345678 to 0x44 after the line is loaded -> no stall, no mem_req; subsequent read of 0x44 returns 0x12345678 with zero latency.
- Dirty eviction: with line 2 dirty (tag A), read 0x00000440 (same index, different tag) -> write req at 0x40 carrying 0x12345678 in word1, ack, then read req at 0x440, ack, stall released.
- Read+write both high at 0x48, data 0x0000AAAA -> handled as a write; read back 0x48 = 0x0000AAAA.
- Reset during ALLOCATE: assert rst_i one cycle while mem_req_o=1 -> mem_req_o=0 and stall_o=0 next cycle; later ack ignored; read of 0x40 misses again.
- DCACHE_STATS_EN: run the sequence cold read, hit, hit, dirty miss -> hit_cnt_o=2, miss_cnt_o=2, wb_cnt_o=1.

Source files
------------

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back write-allocate data cache between the CPU MEM stage and a block-wide memory
// Ports: clk_i/rst_i clock and sync active-high reset; memRead_i/memWrite_i/addr_i/wdata_i CPU request;
// rdata_o/stall_o CPU response; mem_req_o/mem_write_o/mem_addr_o/mem_wdata_o backing request;
// mem_rdata_i/mem_ack_i backing response. Define DCACHE_STATS_EN to add hit_cnt_o/miss_cnt_o/wb_cnt_o.
module dcache_ctrl #(
    parameter int LINES       = 32,
    parameter int BLOCK_WORDS = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     memRead_i,
    input  logic                     memWrite_i,
    input  logic [31:0]              addr_i,
    input  logic [31:0]              wdata_i,
    output logic [31:0]              rdata_o,
    output logic                     stall_o,
    output logic                     mem_req_o,
    output logic                     mem_write_o,
    output logic [31:0]              mem_addr_o,
    output logic [32*BLOCK_WORDS-1:0] mem_wdata_o,
    input  logic [32*BLOCK_WORDS-1:0] mem_rdata_i,
    input  logic                     mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]              hit_cnt_o,
    output logic [31:0]              miss_cnt_o,
    output logic [31:0]              wb_cnt_o
`endif
);
    localparam int OW = $clog2(BLOCK_WORDS);
    localparam int IW = $clog2(LINES);
    localparam int TW = 30 - OW - IW;
    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;
    state_t                   r_state;
    logic [LINES-1:0]         r_valid, r_dirty;
    logic [TW-1:0]            r_tag [LINES];
    logic [32*BLOCK_WORDS-1:0] r_data [LINES];
    logic [TW-1:0]            r_miss_tag;
    logic [IW-1:0]            r_miss_idx;
    logic [OW-1:0]            w_off;
    logic [IW-1:0]            w_idx;
    logic [TW-1:0]            w_tag;
    logic                     w_req, w_hit, w_unused;
    assign w_unused = ^addr_i[1:0];
    assign w_off    = addr_i[OW+1:2];
    assign w_idx    = addr_i[OW+IW+1:OW+2];
    assign w_tag    = addr_i[31:OW+IW+2];
    assign w_req    = memRead_i | memWrite_i;
    assign w_hit    = r_state == IDLE && r_valid[w_idx] && r_tag[w_idx] == w_tag;
    assign stall_o  = r_state != IDLE || (w_req && !w_hit);
    assign rdata_o  = memRead_i && w_hit ? r_data[w_idx][{w_off, 5'b0} +: 32] : 32'h0;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_valid     <= '0;
            r_dirty     <= '0;
            mem_req_o   <= 1'b0;
            mem_write_o <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            case (r_state)
                IDLE:
                    if (w_req && w_hit) begin
                        if (memWrite_i) begin
                            r_data[w_idx][{w_off, 5'b0} +: 32] <= wdata_i;
                            r_dirty[w_idx] <= 1'b1;
                        end
                    end else if (w_req) begin
                        // the CPU holds its request, so only tag and index need latching for the refill
                        r_miss_tag <= w_tag;
                        r_miss_idx <= w_idx;
                        mem_req_o  <= 1'b1;
                        if (r_valid[w_idx] && r_dirty[w_idx]) begin
                            r_state     <= WRITEBACK;
                            mem_write_o <= 1'b1;
                            mem_addr_o  <= {r_tag[w_idx], w_idx, {(OW+2){1'b0}}};
                            mem_wdata_o <= r_data[w_idx];
                        end else begin
                            r_state     <= ALLOCATE;
                            mem_write_o <= 1'b0;
                            mem_addr_o  <= {w_tag, w_idx, {(OW+2){1'b0}}};
                        end
                    end
                WRITEBACK:
                    if (mem_ack_i) begin
                        r_state     <= ALLOCATE;
                        mem_write_o <= 1'b0;
                        mem_addr_o  <= {r_miss_tag, r_miss_idx, {(OW+2){1'b0}}};
                        mem_wdata_o <= '0;
                    end
                ALLOCATE:
                    if (mem_ack_i) begin
                        r_state             <= IDLE;
                        mem_req_o           <= 1'b0;
                        r_data[r_miss_idx]  <= mem_rdata_i;
                        r_tag[r_miss_idx]   <= r_miss_tag;
                        r_valid[r_miss_idx] <= 1'b1;
                        r_dirty[r_miss_idx] <= 1'b0;
                    end
                default: r_state <= IDLE;
            endcase
        end
    end
`ifdef DCACHE_STATS_EN
    // r_refilled marks the re-lookup right after a refill so it is not counted as a second hit
    logic r_refilled;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
            wb_cnt_o   <= '0;
            r_refilled <= 1'b0;
        end else begin
            r_refilled <= r_state == ALLOCATE && mem_ack_i;
            if (r_state == IDLE && w_req && !w_hit) miss_cnt_o <= miss_cnt_o + 32'd1;
            if (w_req && w_hit && !r_refilled) hit_cnt_o <= hit_cnt_o + 32'd1;
            if (r_state == WRITEBACK && mem_ack_i) wb_cnt_o <= wb_cnt_o + 32'd1;
        end
    end
`endif
endmodule
